clk_enable_gen: RTL and testbench
=================================

# clk_enable_gen

Lock-supervised, N-channel fractional clock-enable generator. It runs in the PLL output domain, for example 125 MHz, and releases a clean synchronous reset only after the PLL lock has been stable for long enough. It then produces per-channel single-cycle enable pulses at programmable rates, such as the 3.5 MHz CPU enable and pixel/audio enables. Rates can be retuned at runtime without glitches, and loss of lock is detected and counted.

## Interface
Parameters:
- CHANNELS, 2, number of independent enable channels (1–8).
- ACC_W, 32, phase-accumulator and increment width (8–32).
- LOCK_CYCLES, 1024, consecutive high `pll_lock` cycles required before leaving reset (≥2).
- INC_INIT, all zero, CHANNELS*ACC_W-bit reset increments; channel i occupies bits [i*ACC_W +: ACC_W].

Ports:
- clkin  in  1  PLL output clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- pll_lock  in  1  raw PLL LOCK; already in the clkin domain.
- inc_wr  in  1  increment write strobe.
- inc_sel  in  $clog2(CHANNELS) (min 1)  channel selected by inc_wr.
- inc_data  in  ACC_W  new increment.
- ce  out  CHANNELS  per-channel one-cycle enable pulses.
- rst_out  out  1  synchronous active-high reset for downstream logic.
- locked  out  1  high in RUN.
- relock_cnt  out  8  saturating count of lock losses while in RUN.

## Operation
- FSM states: WAIT_LOCK, STABLE, RUN, LOST. Reset state is WAIT_LOCK.
- WAIT_LOCK: on pll_lock=1, clear the stability counter and go to STABLE.
- STABLE: the counter increments while pll_lock=1.
  - pll_lock=0 → WAIT_LOCK.
  - Counter reaches LOCK_CYCLES-1 with pll_lock=1 → RUN.
- RUN: if pll_lock=0 → LOST.
- LOST: relock_cnt increments, saturating at 255. Next state is always WAIT_LOCK.
- rst_out is 1 in every state except RUN. locked is 1 only in RUN. Both are registered.
- Per channel: an active increment `inc` and a pending increment `pend` with a valid flag.
  - Each RUN cycle: {carry, acc} = acc + inc (ACC_W+1 bits). ce[i] is the registered carry.
  - Rate: f_ce = f_clkin × inc / 2^ACC_W. inc=0 means the channel is silent. inc ≥ 2^(ACC_W-1) yields ce on every carry, at most one pulse per cycle.
- Retune: inc_wr loads pend[inc_sel] and sets valid.
  - In RUN, pend is copied to inc in the cycle the channel's carry is generated, so the new rate starts from the next accumulation. The accumulator is not cleared.
  - Outside RUN, pend is copied on the following cycle.
  - inc_sel ≥ CHANNELS: the write is ignored.
  - Write to the same channel twice before the transfer: last write wins.
- Outside RUN, all accumulators are held at 0 and ce=0. Every channel therefore starts phase-aligned on entering RUN.

## Timing
- Reset values: ce=0, rst_out=1, locked=0, relock_cnt=0, acc=0, inc=INC_INIT slices, pend valid=0, state WAIT_LOCK. reset overrides every other input in the same edge.
- Lock-to-release:
  - pll_lock rises at cycle 0 → state STABLE at cycle 1.
  - rst_out falls and locked rises at cycle LOCK_CYCLES+1.
  - A single low pll_lock cycle in STABLE restarts the whole sequence.
- Lock loss:
  - pll_lock falls at cycle 0 while in RUN → state LOST at cycle 1. rst_out=1, locked=0 and ce=0 from cycle 1.
  - relock_cnt updates at cycle 2.
- ce latency: first pulse of channel i appears ceil(2^ACC_W / inc) cycles after locked rises. A pulse never lasts more than one cycle.
- inc_wr and a carry on the same channel in the same cycle: the currently pending value transfers, and the new write becomes pending.

## Configuration
- CLKEN_RELOCK_CNT_EN defined: relock_cnt behaves as above.
- Not defined: relock_cnt is tied to 0, the counter logic is omitted, and LOST still lasts one cycle.

## Test plan
- Lock qualify: LOCK_CYCLES=16; pll_lock high at cycle 0 → rst_out falls at exactly cycle 17. Repeat with a one-cycle low at cycle 8 → release at cycle 26.
- Rate: ACC_W=32, inc=0x80000000 → ce every 2nd cycle. inc=0x072B020C (3.5 MHz @125 MHz) → 3500±1 pulses in 125000 cycles.
- Glitch-free retune: channel 0 at 0x40000000, write 0x20000000 mid-period → the current period completes at 4 cycles, then periods are 8 cycles. No short or double pulse.
- Lock loss in RUN: drop pll_lock for 1 cycle → ce=0 and rst_out=1 next cycle; relock_cnt 0→1 (0 with the macro undefined); re-release after LOCK_CYCLES.
- Saturation and reset: 300 lock losses → relock_cnt=255. Assert reset mid-RUN → every output is at its reset value on the next cycle, and increments revert to INC_INIT.
- Edge writes: inc_sel=CHANNELS is ignored. inc=0 gives no pulses for 10000 cycles. Two writes before a carry → only the second takes effect.

Source files
------------

// File: rtl/clk_enable_gen_if.sv
// Increment-programming bus for clk_enable_gen: write strobe, channel select and new increment.
interface clk_enable_gen_if #(
    parameter int CHANNELS = 2,
    parameter int ACC_W    = 32
);
    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic             inc_wr;
    logic [SEL_W-1:0] inc_sel;
    logic [ACC_W-1:0] inc_data;

    modport master (output inc_wr, inc_sel, inc_data);
    modport slave  (input  inc_wr, inc_sel, inc_data);
endinterface

// File: rtl/clk_enable_gen.sv
// Lock-supervised N-channel fractional clock-enable generator with glitch-free retune.
// Optional lock-loss counter enabled by defining CLKEN_RELOCK_CNT_EN.
module clk_enable_gen #(
    parameter int                        CHANNELS    = 2,
    parameter int                        ACC_W       = 32,
    parameter int                        LOCK_CYCLES = 1024,
    parameter logic [CHANNELS*ACC_W-1:0] INC_INIT    = '0
) (
    input  logic                 clkin,
    input  logic                 reset,
    input  logic                 pll_lock,
    clk_enable_gen_if.slave      cfg,
    output logic [CHANNELS-1:0]  ce,
    output logic                 rst_out,
    output logic                 locked,
    output logic [7:0]           relock_cnt
);
    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CNT_W = $clog2(LOCK_CYCLES);

    typedef enum logic [1:0] {WAIT_LOCK, STABLE, RUN, LOST} state_t;
    typedef logic [ACC_W-1:0] word_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rst_out_q, locked_q;
    logic [CHANNELS-1:0] ce_q, ce_d;
    word_t              acc_q [CHANNELS];
    word_t              acc_d [CHANNELS];
    word_t              inc_q [CHANNELS];
    word_t              inc_d [CHANNELS];
    word_t              pend_q [CHANNELS];
    word_t              pend_d [CHANNELS];
    logic [CHANNELS-1:0] pend_vld_q, pend_vld_d;
    logic [ACC_W:0]     sum [CHANNELS];
    logic [CHANNELS-1:0] xfer, wr;
    logic               run_q, stay_run;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            WAIT_LOCK: if (pll_lock) begin
                cnt_d   = '0;
                state_d = STABLE;
            end
            STABLE: begin
                if (!pll_lock)                             state_d = WAIT_LOCK;
                else if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) state_d = RUN;
                else                                       cnt_d   = cnt_q + CNT_W'(1);
            end
            RUN:     if (!pll_lock) state_d = LOST;
            LOST:    state_d = WAIT_LOCK;
            default: state_d = WAIT_LOCK;
        endcase
    end

    assign run_q    = (state_q == RUN);
    // Accumulate only across RUN->RUN edges so acc and ce are already 0 in the first LOST cycle.
    assign stay_run = run_q && (state_d == RUN);

    always_comb begin
        ce_d       = '0;
        xfer       = '0;
        wr         = '0;
        pend_vld_d = pend_vld_q;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            sum[i]    = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
            acc_d[i]  = stay_run ? sum[i][ACC_W-1:0] : '0;
            ce_d[i]   = stay_run & sum[i][ACC_W];
            // In RUN the pending rate lands exactly on a carry, so no period is ever cut short.
            xfer[i]   = pend_vld_q[i] & (run_q ? sum[i][ACC_W] : 1'b1);
            inc_d[i]  = xfer[i] ? pend_q[i] : inc_q[i];
            wr[i]     = cfg.inc_wr && (cfg.inc_sel == SEL_W'(i));
            pend_d[i] = wr[i] ? cfg.inc_data : pend_q[i];
            pend_vld_d[i] = wr[i] | (pend_vld_q[i] & ~xfer[i]);
        end
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q    <= WAIT_LOCK;
            cnt_q      <= '0;
            rst_out_q  <= 1'b1;
            locked_q   <= 1'b0;
            ce_q       <= '0;
            pend_vld_q <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                acc_q[i]  <= '0;
                inc_q[i]  <= INC_INIT[i*ACC_W +: ACC_W];
                pend_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rst_out_q  <= (state_d != RUN);
            locked_q   <= (state_d == RUN);
            ce_q       <= ce_d;
            pend_vld_q <= pend_vld_d;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                acc_q[i]  <= acc_d[i];
                inc_q[i]  <= inc_d[i];
                pend_q[i] <= pend_d[i];
            end
        end
    end

`ifdef CLKEN_RELOCK_CNT_EN
    logic [7:0] relock_q, relock_d;

    always_comb begin
        relock_d = relock_q;
        if (state_q == LOST && relock_q != 8'hFF) relock_d = relock_q + 8'd1;
    end

    always_ff @(posedge clkin) begin
        if (reset) relock_q <= '0;
        else       relock_q <= relock_d;
    end

    assign relock_cnt = relock_q;
`else
    assign relock_cnt = '0;
`endif

    assign ce      = ce_q;
    assign rst_out = rst_out_q;
    assign locked  = locked_q;
endmodule

// File: tb/tb_clk_enable_gen.sv
// Self-checking bench for clk_enable_gen: directed tables/sequences plus random stimulus vs a streak/phase model.
module tb_clk_enable_gen;
    localparam int CH = 3;
    localparam int W  = 32;
    localparam int LC = 16;
    localparam logic [CH*W-1:0] INIT = {32'h4000_0000, 32'h0, 32'h0};
    localparam longint unsigned TWO32 = 64'h1_0000_0000;
`ifdef CLKEN_RELOCK_CNT_EN
    localparam bit RELOCK_EN = 1'b1;
`else
    localparam bit RELOCK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          pll_lock;
    logic [CH-1:0] ce;
    logic          rst_out, locked;
    logic [7:0]    relock_cnt;

    clk_enable_gen_if #(.CHANNELS(CH), .ACC_W(W)) bus ();

    clk_enable_gen #(
        .CHANNELS(CH), .ACC_W(W), .LOCK_CYCLES(LC), .INC_INIT(INIT)
    ) dut (
        .clkin(clk), .reset(reset), .pll_lock(pll_lock), .cfg(bus.slave),
        .ce(ce), .rst_out(rst_out), .locked(locked), .relock_cnt(relock_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference: release after LC+1 consecutive high lock samples; phases as exact integers.
    bit              m_run, m_lost;
    int              m_streak, m_relock;
    longint unsigned m_acc [CH];
    longint unsigned m_inc [CH];
    longint unsigned m_pend [CH];
    bit              m_vld [CH];
    logic [CH-1:0]   m_ce;
    longint unsigned init_inc [CH] = '{64'h0, 64'h0, 64'h4000_0000};

    task automatic model_step();
        bit was_run, both, c, xf;
        longint unsigned s;
        if (reset) begin
            m_run = 0; m_lost = 0; m_streak = 0; m_relock = 0; m_ce = '0;
            for (int i = 0; i < CH; i++) begin
                m_acc[i] = 0; m_inc[i] = init_inc[i]; m_pend[i] = 0; m_vld[i] = 0;
            end
        end else begin
            was_run = m_run;
            if (m_run) begin
                if (!pll_lock) begin m_run = 0; m_lost = 1; end
            end else if (m_lost) begin
                m_lost = 0;
                if (RELOCK_EN && m_relock < 255) m_relock++;
            end else begin
                m_streak = pll_lock ? m_streak + 1 : 0;
                if (m_streak == LC + 1) begin m_run = 1; m_streak = 0; end
            end
            both = was_run && m_run;
            for (int i = 0; i < CH; i++) begin
                s = m_acc[i] + m_inc[i];
                c = (s >= TWO32);
                m_ce[i]  = both && c;
                m_acc[i] = both ? (s % TWO32) : 0;
                xf = m_vld[i] && (was_run ? c : 1'b1);
                if (xf) begin m_inc[i] = m_pend[i]; m_vld[i] = 0; end
                if (bus.inc_wr && int'(bus.inc_sel) == i) begin
                    m_pend[i] = bus.inc_data; m_vld[i] = 1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        checks++;
        if (ce !== m_ce || rst_out !== !m_run || locked !== m_run || relock_cnt !== 8'(m_relock)) begin
            errors++;
            $display("FAIL model cyc=%0d got ce=%b rst_out=%b locked=%b relock=%0d exp ce=%b rst_out=%b locked=%b relock=%0d",
                     cyc, ce, rst_out, locked, relock_cnt, m_ce, !m_run, m_run, m_relock);
        end
    endtask

    task automatic check(input string name, input longint unsigned got, input longint unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic qualify(input int low_at, output int n);
        n = 0;
        for (int k = 0; k < 200; k++) begin
            pll_lock = (k == low_at) ? 1'b0 : 1'b1;
            tick();
            if (!rst_out) begin n = k + 1; break; end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; tick(); reset = 1'b0;
    endtask

    task automatic lock_up();
        bit up = 0;
        pll_lock = 1'b1;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (locked) begin up = 1; break; end
        end
        check("lock_up", up, 1);
    endtask

    typedef struct {
        logic [W-1:0] inc;
        int           window;
        int           exp_lat;
        int           exp_cnt;
    } rate_t;

    rate_t rates [5];

    initial begin
        int n, first, cnt, c1, c2f, c2n;
        int pos [$];
        int exp_pos [8] = '{4, 12, 20, 28, 36, 40, 44, 48};

        rates[0] = '{32'h8000_0000,    64,  2,  32};
        rates[1] = '{32'h4000_0000,    64,  4,  16};
        rates[2] = '{32'hFFFF_FFFF,    64,  2,  63};
        rates[3] = '{32'h0000_0000, 10000,  0,   0};
        rates[4] = '{32'h072B_020C, 25000, 36, 699};

        reset = 1'b1; pll_lock = 1'b0;
        bus.inc_wr = 1'b0; bus.inc_sel = '0; bus.inc_data = '0;
        tick(); tick();
        check("reset_ce", ce, 0);
        check("reset_rst_out", rst_out, 1);
        check("reset_locked", locked, 0);
        check("reset_relock", relock_cnt, 0);

        reset = 1'b0; tick();
        qualify(-1, n);
        check("release_cycle", n, 17);

        pll_lock = 1'b0; tick();
        check("loss_rst_out", rst_out, 1);
        check("loss_locked", locked, 0);
        check("loss_ce", ce, 0);
        check("loss_relock_early", relock_cnt, 0);
        tick();
        check("loss_relock", relock_cnt, RELOCK_EN ? 1 : 0);
        qualify(8, n);
        check("release_glitch_cycle", n, 26);

        foreach (rates[r]) begin
            pll_lock = 1'b0;
            do_reset();
            bus.inc_wr = 1'b1; bus.inc_sel = 2'd0; bus.inc_data = rates[r].inc;
            tick();
            bus.inc_wr = 1'b0;
            tick();
            lock_up();
            first = 0; cnt = 0;
            for (int c = 1; c <= rates[r].window; c++) begin
                tick();
                if (ce[0]) begin
                    cnt++;
                    if (first == 0) first = c;
                end
            end
            check($sformatf("rate%0d_latency", r), first, rates[r].exp_lat);
            check($sformatf("rate%0d_count", r), cnt, rates[r].exp_cnt);
        end

        // Retune mid-period, ignored out-of-range select, then two writes before a carry.
        pll_lock = 1'b0;
        do_reset();
        bus.inc_wr = 1'b1; bus.inc_sel = 2'd0; bus.inc_data = 32'h4000_0000;
        tick();
        bus.inc_wr = 1'b0;
        tick();
        lock_up();
        c1 = 0;
        for (int c = 1; c <= 50; c++) begin
            bus.inc_wr = 1'b0;
            if (c == 3)  begin bus.inc_wr = 1'b1; bus.inc_sel = 2'd0; bus.inc_data = 32'h2000_0000; end
            if (c == 6)  begin bus.inc_wr = 1'b1; bus.inc_sel = 2'd3; bus.inc_data = 32'h8000_0000; end
            if (c == 31) begin bus.inc_wr = 1'b1; bus.inc_sel = 2'd0; bus.inc_data = 32'h8000_0000; end
            if (c == 32) begin bus.inc_wr = 1'b1; bus.inc_sel = 2'd0; bus.inc_data = 32'h4000_0000; end
            tick();
            if (ce[0]) pos.push_back(c);
            if (ce[1]) c1++;
        end
        bus.inc_wr = 1'b0;
        check("retune_pulses", pos.size(), 8);
        for (int k = 0; k < 8; k++)
            check($sformatf("retune_pos%0d", k), (k < pos.size()) ? pos[k] : -1, exp_pos[k]);
        check("bad_sel_ch1_silent", c1, 0);

        for (int k = 0; k < 300; k++) begin
            pll_lock = 1'b0; tick(); tick();
            qualify(-1, n);
        end
        check("relock_saturate", relock_cnt, RELOCK_EN ? 255 : 0);

        reset = 1'b1; tick();
        check("midrun_reset_ce", ce, 0);
        check("midrun_reset_rst_out", rst_out, 1);
        check("midrun_reset_locked", locked, 0);
        check("midrun_reset_relock", relock_cnt, 0);
        reset = 1'b0;
        lock_up();
        cnt = 0; c2f = 0; c2n = 0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (ce[0]) cnt++;
            if (ce[2]) begin
                c2n++;
                if (c2f == 0) c2f = c;
            end
        end
        check("revert_ch0_silent", cnt, 0);
        check("revert_ch2_first", c2f, 4);
        check("revert_ch2_count", c2n, 4);

        do_reset();
        for (int k = 0; k < 4000; k++) begin
            reset        = ($urandom_range(0, 999) == 0);
            pll_lock     = ($urandom_range(0, 99) < 97);
            bus.inc_wr   = ($urandom_range(0, 9) == 0);
            bus.inc_sel  = 2'($urandom_range(0, 3));
            bus.inc_data = $urandom >> $urandom_range(0, 6);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
